// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data RAM port between the CPU MEM stage and a debug master
module dmem_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_valid,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_ready,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_we,
    input  logic [DW-1:0] ram_spo
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] starve_cnt;
    logic          gnt_dbg;

    // Debug wins when the CPU is idle, when it has waited long enough, or while it holds the lock.
    always_comb begin
        gnt_dbg = 1'b0;
        if (!reset) begin
            if (state == LOCK) begin
                gnt_dbg = dbg_valid;
            end else begin
                gnt_dbg = dbg_valid && (!cpu_req || starve_cnt == STARVE_LIM);
            end
        end
    end

    assign dbg_ready = gnt_dbg;
    assign cpu_stall = !reset && cpu_req && (gnt_dbg || state == LOCK);
    assign ram_a     = gnt_dbg ? dbg_addr  : cpu_addr;
    assign ram_d     = gnt_dbg ? dbg_wdata : cpu_wdata;
    assign ram_we    = !reset && (gnt_dbg ? dbg_we : (cpu_req && cpu_we && !cpu_stall));
    assign cpu_rdata = ram_spo;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB;
            starve_cnt <= '0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            if (state == ARB) begin
                if (gnt_dbg && dbg_lock) begin
                    state <= LOCK;
                end
            end else if (!dbg_lock) begin
                state <= ARB;
            end

            // Restarting from zero after every grant guarantees the CPU a window between steals.
            if (gnt_dbg) begin
                starve_cnt <= '0;
            end else if (dbg_valid) begin
                if (starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + CW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end

            dbg_rvalid <= gnt_dbg && !dbg_we;
            if (gnt_dbg && !dbg_we) begin
                dbg_rdata <= ram_spo;
            end
        end
    end

endmodule
